// File: rtl/mean_pkg.sv
// Shared constants and FSM encoding for the mean block and its config transmitter.
package mean_pkg;

  localparam int MEAN_FRAME_WIDTH   = 9;
  localparam int MEAN_RESULT_NUMBER = 31;
  localparam int CFG_DEPTH          = 64;
  localparam int CFG_LEN_WIDTH      = 7;

  typedef enum logic [1:0] {
    CFG_IDLE     = 2'd0,
    CFG_PREFETCH = 2'd1,
    CFG_SEND     = 2'd2,
    CFG_DONE     = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/mean_cfg_tbl.sv
// Offset table: one synchronous write port, one registered read port.
module mean_cfg_tbl #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain RAM/flops; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mean_cfg_tx.sv
// Streams the software-loaded offset table to mean once per start, one entry per accepted beat.
module mean_cfg_tx
  import mean_pkg::*;
#(
  parameter int MEAN_FRAME_WIDTH = mean_pkg::MEAN_FRAME_WIDTH,
  parameter int CFG_DEPTH        = mean_pkg::CFG_DEPTH,
  parameter int LEN_WIDTH        = mean_pkg::CFG_LEN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tbl_wr_en,
  input  logic [$clog2(CFG_DEPTH)-1:0] tbl_wr_addr,
  input  logic [MEAN_FRAME_WIDTH-1:0]  tbl_wr_data,
  input  logic [LEN_WIDTH-1:0]         tbl_len,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         wr_err,
  input  logic                         cfg_ready,
  output logic                         cfg_valid,
  output logic [MEAN_FRAME_WIDTH-1:0]  cfg_data,
  output logic                         cfg_last
);

  localparam int IDX_W = $clog2(CFG_DEPTH);
  localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(CFG_DEPTH);

  cfg_state_e           state_q, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_nxt;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_inc;
  logic                 vld_q, last_q, wr_err_q;
  logic                 accept, rd_en;

  assign busy      = (state_q == CFG_PREFETCH) || (state_q == CFG_SEND);
  assign done      = (state_q == CFG_DONE);
  assign wr_err    = wr_err_q;
  // mean counts every valid cycle, so valid is never shown while ready is low.
  assign cfg_valid = vld_q & cfg_ready;
  assign cfg_last  = last_q;
  assign accept    = vld_q & cfg_ready;

  assign cnt_nxt    = cnt_q + 1'b1;
  assign rd_idx_inc = (rd_idx_q == IDX_W'(CFG_DEPTH - 1)) ? '0 : rd_idx_q + 1'b1;
  assign rd_en      = (state_q == CFG_PREFETCH) || ((state_q == CFG_SEND) && accept && !last_q);

  mean_cfg_tbl #(
    .WIDTH (MEAN_FRAME_WIDTH),
    .DEPTH (CFG_DEPTH),
    .ADDR_W(IDX_W)
  ) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tbl_wr_en & ~busy),
    .wr_addr(tbl_wr_addr),
    .wr_data(tbl_wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_idx_q),
    .rd_data(cfg_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CFG_IDLE;
    else     state_q <= state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      CFG_IDLE:     if (start) state_nxt = (tbl_len == '0) ? CFG_DONE : CFG_PREFETCH;
      CFG_PREFETCH: state_nxt = CFG_SEND;
      CFG_SEND:     if (accept && last_q) state_nxt = CFG_DONE;
      CFG_DONE:     state_nxt = CFG_IDLE;
      default:      state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      cnt_q    <= '0;
      rd_idx_q <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= tbl_wr_en & busy;
      case (state_q)
        CFG_IDLE: begin
          if (start && (tbl_len != '0)) begin
            // Clamping to the table depth keeps the read index from wrapping inside a frame.
            len_q    <= (tbl_len > DEPTH_LEN) ? DEPTH_LEN : tbl_len;
            cnt_q    <= '0;
            rd_idx_q <= '0;
          end
        end
        CFG_PREFETCH: begin
          rd_idx_q <= rd_idx_inc;
          vld_q    <= 1'b1;
          last_q   <= (len_q == LEN_WIDTH'(1));
        end
        CFG_SEND: begin
          if (accept) begin
            if (last_q) begin
              vld_q  <= 1'b0;
              last_q <= 1'b0;
            end else begin
              cnt_q    <= cnt_nxt;
              rd_idx_q <= rd_idx_inc;
              last_q   <= (cnt_nxt == len_q - 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mean_cfg_tx.sv
// Directed bench for mean_cfg_tx: frame scenarios from a vector table plus reset and reload sequences.
module tb_mean_cfg_tx;
  import mean_pkg::*;

  localparam int W     = MEAN_FRAME_WIDTH;
  localparam int DEPTH = CFG_DEPTH;
  localparam int LW    = CFG_LEN_WIDTH;

  typedef enum int {M_PLAIN, M_TOGGLE, M_INJECT, M_WRSTART} mode_e;

  typedef struct {
    int    len;
    mode_e mode;
    int    exp_beats;
    int    exp_first;
    int    exp_done;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     tbl_wr_en = 1'b0;
  logic [$clog2(DEPTH)-1:0] tbl_wr_addr = '0;
  logic [W-1:0]             tbl_wr_data = '0;
  logic [LW-1:0]            tbl_len = '0;
  logic                     start = 1'b0;
  logic                     busy, done, wr_err;
  logic                     cfg_ready = 1'b1;
  logic                     cfg_valid, cfg_last;
  logic [W-1:0]             cfg_data;

  logic [W-1:0] model [DEPTH];
  vec_t         vecs [7];
  int           n_checks = 0;
  int           n_err    = 0;

  mean_cfg_tx dut (
    .clk        (clk),
    .rst        (rst),
    .tbl_wr_en  (tbl_wr_en),
    .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data),
    .tbl_len    (tbl_len),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err),
    .cfg_ready  (cfg_ready),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_pat(input int s);
    return ((s % 16) < 4) || ((s % 16) >= 12);
  endfunction

  // Called and returns at posedge+1.
  task automatic tbl_write(input int addr, input logic [W-1:0] data);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = addr[$clog2(DEPTH)-1:0];
    tbl_wr_data = data;
    @(posedge clk); #1;
    tbl_wr_en = 1'b0;
    model[addr] = data;
  endtask

  // Sample s is taken on the negedge after the s-th edge following the start edge.
  task automatic run_frame(input vec_t v);
    int nbeats = 0;
    int first_s = -1;
    int done_s = -1;
    int ndone = 0;
    start   = 1'b1;
    tbl_len = LW'(v.len);
    cfg_ready = 1'b1;
    if (v.mode == M_WRSTART) begin
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = '0;
      tbl_wr_data = 9'h155;
      model[0]    = 9'h155;
    end
    @(posedge clk); #1;
    start     = 1'b0;
    tbl_wr_en = 1'b0;
    for (int s = 0; s <= v.exp_done + 4; s++) begin
      cfg_ready = (v.mode == M_TOGGLE) ? ready_pat(s) : 1'b1;
      if (v.mode == M_INJECT) begin
        tbl_wr_en   = (s == 3);
        tbl_wr_addr = 5;
        tbl_wr_data = '1;
        start       = (s == 6);
        tbl_len     = LW'(31);
      end
      @(negedge clk);
      if (s == 0) check("busy_after_start", busy, v.len != 0);
      if (!cfg_ready) check("valid_gated", cfg_valid, 1'b0);
      check("wr_err", wr_err, (v.mode == M_INJECT) && (s == 4));
      if (cfg_valid) begin
        if (first_s < 0) first_s = s;
        check("beat_data", cfg_data, model[nbeats % DEPTH]);
        check("beat_last", cfg_last, nbeats == v.exp_beats - 1);
        nbeats++;
      end
      if (done) begin
        ndone++;
        if (done_s < 0) done_s = s;
      end
      @(posedge clk); #1;
    end
    tbl_wr_en = 1'b0;
    start     = 1'b0;
    check("beat_count",  nbeats,  v.exp_beats);
    check("first_valid", first_s, v.exp_first);
    check("done_cycle",  done_s,  v.exp_done);
    check("done_count",  ndone,   1);
    check("busy_end",    busy,    1'b0);
  endtask

  initial begin
    vecs[0] = '{len: 31,  mode: M_PLAIN,   exp_beats: 31, exp_first: 1,  exp_done: 32};
    vecs[1] = '{len: 31,  mode: M_TOGGLE,  exp_beats: 31, exp_first: 1,  exp_done: 64};
    vecs[2] = '{len: 0,   mode: M_PLAIN,   exp_beats: 0,  exp_first: -1, exp_done: 0};
    vecs[3] = '{len: 1,   mode: M_PLAIN,   exp_beats: 1,  exp_first: 1,  exp_done: 2};
    vecs[4] = '{len: 31,  mode: M_INJECT,  exp_beats: 31, exp_first: 1,  exp_done: 32};
    vecs[5] = '{len: 100, mode: M_PLAIN,   exp_beats: 64, exp_first: 1,  exp_done: 65};
    vecs[6] = '{len: 1,   mode: M_WRSTART, exp_beats: 1,  exp_first: 1,  exp_done: 2};

    repeat (2) @(negedge clk);
    check("rst_busy",   busy,      1'b0);
    check("rst_done",   done,      1'b0);
    check("rst_wr_err", wr_err,    1'b0);
    check("rst_valid",  cfg_valid, 1'b0);
    check("rst_last",   cfg_last,  1'b0);
    check("rst_data",   cfg_data,  '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Offsets 0,3,7,10,14,... (floor of 3.5*i), all distinct.
    for (int i = 0; i < DEPTH; i++) tbl_write(i, W'((i * 7) / 2));

    for (int k = 0; k < 7; k++) run_frame(vecs[k]);

    // Reset while beat 10 is on the bus, then a full frame must follow.
    start   = 1'b1;
    tbl_len = LW'(31);
    cfg_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", cfg_valid, 1'b1);
    check("pre_rst_data",  cfg_data,  model[9]);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", cfg_valid, 1'b0);
    check("mid_rst_busy",  busy,      1'b0);
    check("mid_rst_last",  cfg_last,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
